// File: rtl/in_deserialize.sv
// in_deserialize: packs a per-feature serial stream back into wide per-node
// feature words, one INPUT_DIM*PRECISION-bit word per node address. It pulses
// frame completion every WORDS_PER_FRAME words and flags words that are
// abandoned part-way through.
module in_deserialize #(
  parameter int GRAPH_SIZE      = 4,
  parameter int PRECISION       = 8,
  parameter int INPUT_DIM       = 64,
  parameter int ADDR_WIDTH      = $clog2(GRAPH_SIZE*GRAPH_SIZE*GRAPH_SIZE),
  parameter int WORDS_PER_FRAME = GRAPH_SIZE*GRAPH_SIZE,
  parameter int OUT_DATA_WIDTH  = INPUT_DIM*PRECISION
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [PRECISION-1:0]      in_data,
  input  logic                      in_valid,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_we,
  output logic                      out_frame_done,
  output logic                      err_partial
);

  localparam int LANE_W = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
  localparam int FC_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                    state_q, state_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [OUT_DATA_WIDTH-1:0] asm_q, asm_d;
  logic [FC_W-1:0]           frame_cnt_q, frame_cnt_d;
  logic [ADDR_WIDTH-1:0]     out_addr_q, out_addr_d;
  logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_we_q, out_we_d;
  logic                      frame_done_q, frame_done_d;
  logic                      err_q, err_d;
  logic                      complete;

  // Next-state logic: lane assembly, address tracking, completion and frame count
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    cur_addr_d   = cur_addr_q;
    asm_d        = asm_q;
    frame_cnt_d  = frame_cnt_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_we_d     = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    complete     = 1'b0;

    if (in_valid) begin
      if (state_q == IDLE || in_addr != cur_addr_q) begin
        // Start of a new word; in FILL this abandons the partial word.
        if (state_q == FILL) err_d = 1'b1;
        cur_addr_d = in_addr;
        asm_d[PRECISION-1:0] = in_data;
        if (INPUT_DIM == 1) begin
          complete = 1'b1;
          lane_d   = '0;
          state_d  = IDLE;
        end else begin
          lane_d  = LANE_W'(1);
          state_d = FILL;
        end
      end else begin
        asm_d[int'(lane_q)*PRECISION +: PRECISION] = in_data;
        if (lane_q == LANE_W'(INPUT_DIM-1)) begin
          complete = 1'b1;
          lane_d   = '0;
          state_d  = IDLE;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
    end

    // The final beat is merged via asm_d, so the word is written without
    // waiting for the assembly register to update.
    if (complete) begin
      out_we_d   = 1'b1;
      out_addr_d = cur_addr_d;
      out_data_d = asm_d;
      if (frame_cnt_q == FC_W'(WORDS_PER_FRAME-1)) begin
        frame_done_d = 1'b1;
        frame_cnt_d  = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Control and output registers; reset drops any partial word silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      frame_cnt_q  <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      frame_cnt_q  <= frame_cnt_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_we_q     <= out_we_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Assembly datapath: current address and lane contents, never reset
  always_ff @(posedge clk) begin
    cur_addr_q <= cur_addr_d;
    asm_q      <= asm_d;
  end

  assign out_addr       = out_addr_q;
  assign out_data       = out_data_q;
  assign out_we         = out_we_q;
  assign out_frame_done = frame_done_q;
  assign err_partial    = err_q;

endmodule

// File: tb/tb_in_deserialize.sv
module tb_in_deserialize;

  localparam int AW = 6;
  localparam int PW = 8;
  localparam int ND = 64;
  localparam int DW = ND*PW;
  localparam int WPF = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] in_addr = '0;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_we;
  logic          out_frame_done;
  logic          err_partial;

  in_deserialize dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .in_data(in_data),
    .in_valid(in_valid), .out_addr(out_addr), .out_data(out_data),
    .out_we(out_we), .out_frame_done(out_frame_done), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t wq[$];
  int   eq[$];

  // reference model state: beats of the word in progress
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_lanes[$];
  int            m_words = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_beat(input logic [AW-1:0] a, input logic [PW-1:0] d, input int when);
    exp_t e;
    if (m_lanes.size() > 0 && a != m_addr) begin
      eq.push_back(when);
      m_lanes.delete();
    end
    if (m_lanes.size() == 0) m_addr = a;
    m_lanes.push_back(d);
    if (m_lanes.size() == ND) begin
      e.cyc  = when;
      e.addr = m_addr;
      e.data = '0;
      for (int i = 0; i < ND; i++) e.data[i*PW +: PW] = m_lanes[i];
      m_words = (m_words + 1) % WPF;
      e.done = (m_words == 0);
      wq.push_back(e);
      m_lanes.delete();
    end
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [PW-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    model_beat(a, d, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_addr  = AW'($urandom);
      in_data  = PW'($urandom);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_we",   DW'(out_we), '0);
    check("rst_done", DW'(out_frame_done), '0);
    check("rst_err",  DW'(err_partial), '0);
    check("rst_addr", DW'(out_addr), '0);
    check("rst_data", out_data, '0);
  endtask

  task automatic do_reset();
    idle(3);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    m_lanes.delete();
    m_words = 0;
    last_addr = '0;
    last_data = '0;
    @(posedge clk); #1;
    check_reset_outputs();
    reset = 1'b0;
  endtask

  // monitor: pops expectations whenever the DUT presents a write or error
  always @(negedge clk) begin
    if (!reset) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        void'(wq.pop_front());
        fail_now("missed_write");
      end
      while (eq.size() > 0 && eq[0] < cyc) begin
        void'(eq.pop_front());
        fail_now("missed_err_partial");
      end
      if (out_we) begin
        if (wq.size() == 0) fail_now("unexpected_write");
        else begin
          exp_t e;
          e = wq.pop_front();
          check("we_cycle", DW'(cyc), DW'(e.cyc));
          check("out_addr", DW'(out_addr), DW'(e.addr));
          check("out_data", out_data, e.data);
          check("frame_done", DW'(out_frame_done), DW'(e.done));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("done_without_we", DW'(out_frame_done), '0);
        check("hold_addr", DW'(out_addr), DW'(last_addr));
        check("hold_data", out_data, last_data);
      end
      if (err_partial) begin
        if (eq.size() == 0) fail_now("unexpected_err_partial");
        else check("err_cycle", DW'(cyc), DW'(eq.pop_front()));
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // single word
    for (int i = 0; i < ND; i++) beat(6'd5, PW'(i));
    idle(4);

    // gapped stream: 3 idle cycles after every 7th beat
    for (int i = 0; i < ND; i++) begin
      beat(6'd5, PW'(i));
      if (i % 7 == 6) idle(3);
    end
    idle(4);

    // broken word: abandoned at addr 2, completed at addr 9
    for (int i = 0; i < 10; i++) beat(6'd2, PW'($urandom));
    for (int i = 0; i < ND; i++) beat(6'd9, PW'(8'hA0 + i));
    idle(4);

    // full frame plus one word, back to back
    do_reset();
    for (int w = 0; w < WPF + 1; w++)
      for (int i = 0; i < ND; i++) beat(AW'(w), PW'($urandom));
    idle(4);

    // reset mid-word
    for (int i = 0; i < 30; i++) beat(6'd3, PW'($urandom));
    do_reset();
    for (int i = 0; i < ND; i++) beat(6'd7, PW'($urandom));
    idle(4);

    // continuous back-to-back pair
    for (int i = 0; i < ND; i++) beat(6'd20, PW'($urandom));
    for (int i = 0; i < ND; i++) beat(6'd21, PW'($urandom));
    idle(4);

    // random traffic with gaps and occasional address switches
    for (int w = 0; w < 8; w++) begin
      a = AW'($urandom);
      for (int i = 0; i < ND; i++) begin
        if ($urandom_range(99) == 0) a = AW'($urandom);
        beat(a, PW'($urandom));
        if ($urandom_range(7) == 0) idle($urandom_range(3, 1));
      end
    end
    idle(6);

    if (wq.size() != 0) fail_now("writes_outstanding");
    if (eq.size() != 0) fail_now("errors_outstanding");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
